sub_rr_arbiter: RTL
===================

Name: sub_rr_arbiter

Overview:
Shares one add/subtract datapath between NUM_REQ requesters using round-robin arbitration. Each requester presents two operands and an op select. The block grants one requester, latches its operands, computes a registered result, then holds that result plus the requester ID until the downstream consumer reads it. It sits between the per-lane operand FIFOs and the shared result FIFO.

Parameters:
DATA_WIDTH, 32, operand/result width in bits
NUM_REQ, 4, number of requesters (>=2)
ID_W, $clog2(NUM_REQ), width of requester ID

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  NUM_REQ  per-requester operands available
req_sub  in  NUM_REQ  per-requester op: 1 = op1-op2, 0 = op1+op2
req_op1  in  NUM_REQ*DATA_WIDTH  flattened op1; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_op2  in  NUM_REQ*DATA_WIDTH  flattened op2, same packing
req_ready  out  NUM_REQ  one-hot accept; operands consumed on the clock edge where ready&valid
res_valid  out  1  result held and available
res_data  out  DATA_WIDTH  result, modulo 2^DATA_WIDTH
res_id  out  ID_W  index of the requester that owns res_data
res_flag  out  1  subtract: unsigned borrow (op1<op2); add: carry-out
res_rd_en  in  1  consumer read strobe; pops the held result
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, res_valid=0, res_data=0, res_id=0, res_flag=0, operand latches=0. Any in-flight or held result is discarded.
- req_ready is combinational from state, rr_ptr and req_valid. It is zero outside IDLE, at most one bit set, and only set on a bit whose req_valid is high.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE with no req_valid: stay in IDLE.
  - IDLE with any req_valid: grant g = first valid index scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ). Assert req_ready[g]. On the edge, latch op1, op2, sub and id=g. Set rr_ptr=(g+1) mod NUM_REQ (wraps NUM_REQ-1 -> 0). Go to EXEC.
  - EXEC: on the edge, register res_data, res_flag and res_id from the addsub_unit output. Set res_valid=1. Go to HOLD.
  - HOLD: res_valid, res_data, res_id and res_flag are stable. With res_rd_en=1, res_valid clears on the edge and the FSM goes to IDLE. With res_rd_en=0, it stays in HOLD indefinitely.
- Latency: grant in cycle N; res_valid=1 from cycle N+2. Minimum issue interval is 3 cycles (no grant in the cycle res_rd_en pops).
- res_rd_en while res_valid=0 is ignored.
- Changes to req_valid or operands after the grant edge do not affect the in-flight result.
- Arithmetic: both operands are unsigned DATA_WIDTH. Result is truncated to DATA_WIDTH. Borrow/carry is the extra bit of a DATA_WIDTH+1 computation; no overflow exception.
- Reset asserted in EXEC or HOLD: outputs go to their reset values immediately. After release, arbitration restarts from rr_ptr=0.

Decomposition:
- Package sub_arb_pkg:
  - state_t enum {IDLE, EXEC, HOLD}
  - localparams OP_ADD=1'b0, OP_SUB=1'b1
- Sub-module addsub_unit #(DATA_WIDTH): purely combinational.
  - inputs: op, a, b
  - outputs: result, flag
  - instantiated once; it is the shared resource.
- The round-robin pick is a function in the top module; it is not a separate module.

Test Plan:
1. Only req_valid[0]=1, op1=10, op2=3, sub=1.
   -> req_ready=4'b0001 in cycle 0; res_valid=1 in cycle 2 with res_data=7, res_id=0, res_flag=0; held until res_rd_en.
2. Req 1: sub 3-10, then add 0xFFFFFFFF+1.
   -> First result: res_data=0xFFFFFFF9, res_flag=1.
   -> Second result: res_data=0x00000000, res_flag=1.
3. All four req_valid held high, res_rd_en tied to 1.
   -> Grant order 0,1,2,3,0,1; a grant every 3 cycles; res_id follows the same order.
4. Backpressure: res_rd_en=0 for 5 cycles during HOLD.
   -> res_data, res_id and res_flag stable; req_ready=0; busy=1.
   -> One cycle after res_rd_en pulses, a new grant issues.
5. Pointer wrap: grant to requester 3, then only req 1 and 2 valid.
   -> Next grant is 1 (rr_ptr wrapped to 0).
   -> Then only req 2 valid: grant 2.
6. Assert reset during EXEC.
   -> res_valid=0 and busy=0 immediately; no stale result after release.
   -> First grant goes to the lowest valid index.

Source files
------------

// File: rtl/sub_arb_pkg.sv
// Shared types for the round-robin add/sub arbiter.
// FSM states and op encodings used by the top and the datapath.
package sub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_unit.sv
// Shared combinational add/subtract datapath.
// flag is the carry-out on add, the unsigned borrow on subtract.
module addsub_unit
    import sub_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  flag
);

    logic [DATA_WIDTH:0] wide;

    // One extra bit holds the carry/borrow of the unsigned operation.
    always_comb begin
        wide = '0;
        if (op == OP_SUB) begin
            wide = {1'b0, a} - {1'b0, b};
        end else begin
            wide = {1'b0, a} + {1'b0, b};
        end
    end

    assign result = wide[DATA_WIDTH-1:0];
    assign flag   = wide[DATA_WIDTH];

endmodule

// File: rtl/sub_rr_arbiter.sv
// Round-robin arbiter sharing one add/sub unit among NUM_REQ lanes.
// Grant, execute, then hold the result until the consumer pops it.
module sub_rr_arbiter
    import sub_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_sub,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          res_valid,
    output logic [DATA_WIDTH-1:0]         res_data,
    output logic [ID_W-1:0]               res_id,
    output logic                          res_flag,
    input  logic                          res_rd_en,
    output logic                          busy
);

    // {found, index}: first valid lane scanning upward from ptr.
    function automatic logic [ID_W:0] rr_pick(
        input logic [NUM_REQ-1:0] v,
        input logic [ID_W-1:0]    ptr
    );
        logic [ID_W:0] res;
        int            j;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (v[j]) begin
                res = {1'b1, ID_W'(j)};
            end
        end
        return res;
    endfunction

    state_t                state_q;
    state_t                state_d;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic                  sub_q;
    logic [ID_W-1:0]       id_q;

    logic [ID_W:0]         pick;
    logic                  grant_any;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       ptr_next;
    logic                  grant_fire;
    logic                  pop;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_flag;

    assign pick      = rr_pick(req_valid, rr_ptr_q);
    assign grant_any = pick[ID_W];
    assign grant_id  = pick[ID_W-1:0];
    assign busy      = (state_q != IDLE);

    always_comb begin
        ptr_next = grant_id + 1'b1;
        if (grant_id == ID_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        grant_fire = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant_id] = 1'b1;
                    grant_fire          = 1'b1;
                    state_d             = EXEC;
                end
            end
            EXEC: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (res_rd_en) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch and pointer advance happen only on the grant edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            sub_q    <= OP_ADD;
            id_q     <= '0;
        end else if (grant_fire) begin
            rr_ptr_q <= ptr_next;
            op1_q    <= req_op1[grant_id*DATA_WIDTH +: DATA_WIDTH];
            op2_q    <= req_op2[grant_id*DATA_WIDTH +: DATA_WIDTH];
            sub_q    <= req_sub[grant_id];
            id_q     <= grant_id;
        end
    end

    addsub_unit #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_addsub (
        .op    (sub_q),
        .a     (op1_q),
        .b     (op2_q),
        .result(alu_result),
        .flag  (alu_flag)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_flag  <= 1'b0;
        end else if (state_q == EXEC) begin
            res_valid <= 1'b1;
            res_data  <= alu_result;
            res_id    <= id_q;
            res_flag  <= alu_flag;
        end else if (pop) begin
            res_valid <= 1'b0;
        end
    end

endmodule
